// File: rtl/add_serial_nbit.sv
// add_serial_nbit: digit-serial big-integer adder with optional subtract mode.
// It adds a WIDTH-bit operand pair DIGIT bits per clock and carries between
// digit cycles. The start/done handshake is driven by the modular-arithmetic
// controller.
//
// Optional feature macro: ADD_SERIAL_SUB_EN
//   defined   -> sub=1 computes A-B (B inverted at latch time, carry-in of 1)
//   undefined -> the sub port is ignored and the block always adds
//
// Ports:
//   clk     in   1      rising-edge clock
//   rst     in   1      synchronous reset, active high
//   start   in   1      request; sampled only in IDLE or DONE
//   ina     in   WIDTH  operand A; sampled on the accepting edge
//   inb     in   WIDTH  operand B; sampled on the accepting edge
//   sub     in   1      1 = A-B (only with ADD_SERIAL_SUB_EN)
//   busy    out  1      high while digits are being processed
//   done    out  1      one-cycle completion pulse
//   result  out  WIDTH  sum/difference mod 2^WIDTH; held until next completion
//   cout    out  1      carry out (add) or not-borrow (sub)
module add_serial_nbit #(
  parameter int unsigned WIDTH = 1024,
  parameter int unsigned DIGIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic             busy_n, done_n;
  logic             accept, last;

  logic [WIDTH-1:0] a_sh, b_sh, acc;
  logic [WIDTH-1:0] acc_next, b_load;
  logic             carry, sub_eff;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   sum;

`ifdef ADD_SERIAL_SUB_EN
  // Two's-complement subtract: invert B once at latch time, carry-in of 1.
  assign sub_eff = sub;
  assign b_load  = sub ? ~inb : inb;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign sub_eff    = 1'b0;
  assign b_load     = inb;
`endif

  // One digit of addition, with the new digit shifted into the top of acc.
  assign sum      = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
  assign acc_next = (acc >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
  assign last     = (cnt == CW'(NDIG - 1));

  // Next-state and registered-output decode.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_n = RUN;
      end
      RUN:  if (last) state_n = DONE;
      DONE: if (start) begin
        accept  = 1'b1;
        state_n = RUN;
      end else begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n == RUN);
    done_n = (state_n == DONE);
  end

  // State and handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Datapath: operand shift registers, accumulator, ripple carry and results.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh  <= ina;
      b_sh  <= b_load;
      carry <= sub_eff;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> DIGIT;
      b_sh  <= b_sh >> DIGIT;
      acc   <= acc_next;
      carry <= sum[DIGIT];
      cnt   <= CW'(cnt + 1'b1);
      if (last) begin
        result <= acc_next;
        cout   <= sum[DIGIT];
      end
    end
  end

endmodule
